// File: rtl/stim_gen.sv
// Pseudo-random beat source on a valid/ready stream. Start to first beat is 1 cycle, then one beat per cycle.
// Beats are held stable while out_ready is low. Optional idle bubbles come from STIM_GEN_BUBBLE_EN.
module stim_gen #(
   parameter int                DATA_W = 32,
   parameter int                CNT_W  = 16,
   parameter logic [DATA_W-1:0] SEED   = 32'h0000_0001,
   parameter logic [DATA_W-1:0] POLY   = 32'h8020_0003
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_txns,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : SEED;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] lfsr;
   logic [DATA_W-1:0] lfsr_step;
   logic [CNT_W-1:0]  count;
   logic              hs;
   logic              last_beat;

   assign hs        = out_valid && out_ready;
   assign last_beat = (count == {{(CNT_W-1){1'b0}}, 1'b1});
   assign lfsr_step = {1'b0, lfsr[DATA_W-1:1]} ^ (lfsr[0] ? POLY : '0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (num_txns != '0) ? RUN : FIN;
         RUN:  if (hs && last_beat) state_nxt = FIN;
         FIN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The LFSR carries over between runs; only reset reseeds it.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr  <= SEED_EFF;
         count <= '0;
      end else begin
         if (state == IDLE && start) count <= num_txns;
         else if (hs)                count <= count - 1'b1;
         if (hs) lfsr <= lfsr_step;
      end
   end

`ifdef STIM_GEN_BUBBLE_EN
   logic [15:0] bub;
   logic        held;

   // held keeps a presented beat asserted so a bubble never withdraws it.
   always_ff @(posedge clk) begin
      if (rst) begin
         bub  <= 16'hACE1;
         held <= 1'b0;
      end else begin
         bub  <= {1'b0, bub[15:1]} ^ (bub[0] ? 16'hB400 : 16'h0000);
         held <= out_valid && !out_ready;
      end
   end

   assign out_valid = (state == RUN) && (held || (bub[1:0] != 2'b00));
`else
   assign out_valid = (state == RUN);
`endif

   assign out_data = lfsr;
   assign out_last = out_valid && last_beat;
   assign busy     = (state == RUN);
   assign done     = (state == FIN);

endmodule

// File: tb/tb_stim_gen.sv
// Bench for stim_gen: random ready patterns against a reference model of the beat sequence.
module tb_stim_gen;
   localparam logic [31:0] SEED = 32'h0000_0001;
   localparam logic [31:0] POLY = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_txns;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_lfsr;
   logic [31:0] run64 [$];
   logic [31:0] seen64 [$];

   stim_gen #(.DATA_W(32), .CNT_W(16), .SEED(SEED), .POLY(POLY)) dut (
      .clk(clk), .rst(rst), .start(start), .num_txns(num_txns),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] next_val(input logic [31:0] x);
      return (x >> 1) ^ ({32{x[0]}} & POLY);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready=1, 1: toggling, 2: random. pulse_at>=0 re-pulses start after that many beats.
   task automatic run(input int n, input int mode, input int pulse_at, input bit record);
      int beats = 0;
      int cycles = 0;
      int bubbles = 0;
      bit prev_pending = 0;
      bit tog = 1;
      start = 1'b1;
      num_txns = 16'(n);
      out_ready = 1'b1;
      @(negedge clk);
      check("idle_valid", {31'b0, out_valid}, 32'd0);
      step();
      start = 1'b0;
      while (n != 0 && beats < n && cycles < n * 20 + 50) begin
         num_txns = 16'($urandom);
         start = (beats == pulse_at) ? 1'b1 : 1'b0;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = tog;
            default: out_ready = 1'($urandom);
         endcase
         tog = ~tog;
         @(negedge clk);
         check("busy_run", {31'b0, busy}, 32'd1);
         if (prev_pending) check("valid_held", {31'b0, out_valid}, 32'd1);
`ifndef STIM_GEN_BUBBLE_EN
         check("valid_run", {31'b0, out_valid}, 32'd1);
`endif
         if (out_valid) begin
            check("data", out_data, m_lfsr);
            check("last", {31'b0, out_last}, {31'b0, (beats == n - 1)});
            if (out_ready) begin
               if (record) seen64.push_back(out_data);
               beats++;
               m_lfsr = next_val(m_lfsr);
            end
         end else begin
            bubbles++;
         end
         prev_pending = out_valid && !out_ready;
         cycles++;
         step();
      end
      start = 1'b0;
      check("beat_count", beats, n);
`ifdef STIM_GEN_BUBBLE_EN
      if (n >= 64) check("bubbles_seen", {31'b0, (bubbles > 0)}, 32'd1);
`else
      check("no_bubbles", bubbles, 0);
`endif
      @(negedge clk);
      check("done_pulse", {31'b0, done}, 32'd1);
      check("done_busy", {31'b0, busy}, 32'd0);
      check("done_valid", {31'b0, out_valid}, 32'd0);
      step();
      @(negedge clk);
      check("done_clear", {31'b0, done}, 32'd0);
      step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_txns = '0; out_ready = 1'b0;
      m_lfsr = SEED;
      repeat (2) step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_last", {31'b0, out_last}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_data", out_data, SEED);
      step();

      run(4, 0, -1, 0);
      run(3, 1, -1, 0);
      run(0, 0, -1, 0);
      run(8, 0, 3, 0);
      run(2, 2, -1, 0);

      // Reset in the middle of a 5-beat run.
      start = 1'b1; num_txns = 16'd5; out_ready = 1'b1;
      step();
      start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("pre_rst_data", out_data, m_lfsr);
         m_lfsr = next_val(m_lfsr);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      step();
      m_lfsr = SEED;
      run(1, 0, -1, 0);

      for (int i = 0; i < 4; i++) run(int'($urandom_range(1, 12)), 2, -1, 0);

      // 64-beat run from SEED, compared against an independently generated list.
      rst = 1'b1; step(); rst = 1'b0;
      m_lfsr = SEED;
      begin
         logic [31:0] v;
         v = SEED;
         for (int i = 0; i < 64; i++) begin
            run64.push_back(v);
            v = next_val(v);
         end
      end
      run(64, 0, -1, 1);
      check("seq64_len", seen64.size(), 64);
      for (int i = 0; i < 64 && i < seen64.size(); i++)
         if (seen64[i] !== run64[i]) check("seq64_val", seen64[i], run64[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
